// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback source encodings and mul/div sequencer states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

  // Writeback source select encodings (shared with the bypass unit)
  localparam logic [2:0] DIN_PC8 = 3'b001;
  localparam logic [2:0] DIN_DM  = 3'b010;
  localparam logic [2:0] DIN_CP0 = 3'b011;
  localparam logic [2:0] DIN_HI  = 3'b100;
  localparam logic [2:0] DIN_LO  = 3'b101;
  localparam logic [2:0] DIN_ALU = 3'b110;

  // Mul/div sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // True when an ID source read targets a load result that is not yet
  // available from the stage holding destination rw. $0 never hazards.
  function automatic logic load_hit(input logic       rd,
                                    input logic [4:0] idx,
                                    input logic [4:0] rw,
                                    input logic [2:0] sel);
    return rd && (idx == rw) && (rw != 5'd0) && (sel == DIN_DM);
  endfunction

endpackage

// File: rtl/md_seq_ctrl.sv
// Mul/div sequencer: IDLE -> BUSY (N cycles, counting down) -> DONE (1 cycle) -> IDLE.
// Latency: accept sampled at edge t gives md_done high in the cycle after edge t+N.
// Backpressure: none; runs independently of pipe freezes, aborted only by flush or reset.
module md_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       is_div,
  input  logic       flush_req,
  output logic       md_busy,
  output logic       md_done,
  output logic [5:0] md_cnt
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  md_state_t state;

  // Sequencer state, remaining-cycle counter and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      md_cnt  <= 6'd0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= BUSY;
            md_cnt  <= is_div ? DIV_LOAD : MUL_LOAD;
            md_busy <= 1'b1;
          end
        end
        BUSY: begin
          if (flush_req) begin
            // abort: no HI/LO write for a killed operation
            state   <= IDLE;
            md_cnt  <= 6'd0;
            md_busy <= 1'b0;
          end else if (md_cnt == 6'd0) begin
            state   <= DONE;
            md_done <= 1'b1;
          end else begin
            md_cnt <= md_cnt - 6'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          md_cnt  <= 6'd0;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          md_cnt  <= 6'd0;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage interlock: load-use and HI/LO stalls, dmem freeze, flush override, mul/div sequencing.
// Latency: stall/bubble outputs are combinational from inputs and registered mul/div state.
// Backpressure: dmem_wait freezes the whole pipe; lu/hh hold IF/ID and inject an EX bubble.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r1_r_id,
  input  logic       r2_r_id,
  input  logic [4:0] r1_id,
  input  logic [4:0] r2_id,
  input  logic       hilo_r_id,
  input  logic       md_start_id,
  input  logic [4:0] rw_ex,
  input  logic [2:0] din_sel_ex,
  input  logic [4:0] rw_mem,
  input  logic [2:0] din_sel_mem,
  input  logic       md_start_ex,
  input  logic       md_is_div_ex,
  input  logic       dmem_wait,
  input  logic       flush_req,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       md_busy,
  output logic       md_done,
  output logic [5:0] md_cnt
);

  logic lu;
  logic hh;
  logic accept;

  // A load in EX or MEM whose result an ID source needs cannot be bypassed yet
  assign lu = load_hit(r1_r_id, r1_id, rw_ex,  din_sel_ex)
            | load_hit(r2_r_id, r2_id, rw_ex,  din_sel_ex)
            | load_hit(r1_r_id, r1_id, rw_mem, din_sel_mem)
            | load_hit(r2_r_id, r2_id, rw_mem, din_sel_mem);

  // HI/LO readers and new mul/div issues wait for the unit to go idle
  assign hh = (hilo_r_id | md_start_id) & md_busy;

  // A start frozen by dmem_wait or killed by a flush is not launched;
  // a start while busy is ignored.
  assign accept = md_start_ex & ~dmem_wait & ~flush_req & ~md_busy;

  md_seq_ctrl #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .is_div    (md_is_div_ex),
    .flush_req (flush_req),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .md_cnt    (md_cnt)
  );

  // Pipeline control priority: freeze > flush > interlock > run; held low in reset
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    if (rst) begin
      stall_if = 1'b0;
    end else if (dmem_wait) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (flush_req) begin
      // instructions being killed must not hold the pipe
      stall_if = 1'b0;
    end else if (lu | hh) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  import cpu_pkg::*;

  localparam int MULN = 4;
  localparam int DIVN = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       r1_r_id, r2_r_id, hilo_r_id, md_start_id;
  logic [4:0] r1_id, r2_id, rw_ex, rw_mem;
  logic [2:0] din_sel_ex, din_sel_mem;
  logic       md_start_ex, md_is_div_ex, dmem_wait, flush_req;
  logic       stall_if, stall_id, bubble_ex, stall_ex, stall_mem, md_busy, md_done;
  logic [5:0] md_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  // reference model: mul/div tracked as "cycles elapsed since acceptance"
  bit m_act = 1'b0;
  int m_j   = 0;
  int m_n   = 0;

  hazard_stall_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .rst(rst),
    .r1_r_id(r1_r_id), .r2_r_id(r2_r_id), .r1_id(r1_id), .r2_id(r2_id),
    .hilo_r_id(hilo_r_id), .md_start_id(md_start_id),
    .rw_ex(rw_ex), .din_sel_ex(din_sel_ex), .rw_mem(rw_mem), .din_sel_mem(din_sel_mem),
    .md_start_ex(md_start_ex), .md_is_div_ex(md_is_div_ex),
    .dmem_wait(dmem_wait), .flush_req(flush_req),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .stall_ex(stall_ex), .stall_mem(stall_mem),
    .md_busy(md_busy), .md_done(md_done), .md_cnt(md_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit uses_load(bit rd, logic [4:0] idx, logic [4:0] rw, logic [2:0] sel);
    return rd && rw != 5'd0 && idx == rw && sel == 3'b010;
  endfunction

  function automatic logic [12:0] model_exp();
    bit busy, done, lu, hh, sif, sid, bex, sex, smem;
    logic [5:0] cnt;
    busy = m_act;
    done = m_act && (m_j == m_n);
    cnt  = (m_act && m_j < m_n) ? 6'(m_n - 1 - m_j) : 6'd0;
    lu = uses_load(r1_r_id, r1_id, rw_ex, din_sel_ex)   || uses_load(r2_r_id, r2_id, rw_ex, din_sel_ex) ||
         uses_load(r1_r_id, r1_id, rw_mem, din_sel_mem) || uses_load(r2_r_id, r2_id, rw_mem, din_sel_mem);
    hh = (hilo_r_id || md_start_id) && busy;
    {sif, sid, bex, sex, smem} = 5'b0;
    if (rst) {sif, sid, bex, sex, smem} = 5'b0;
    else if (dmem_wait) {sif, sid, bex, sex, smem} = 5'b11011;
    else if (flush_req) {sif, sid, bex, sex, smem} = 5'b0;
    else if (lu || hh) {sif, sid, bex, sex, smem} = 5'b11100;
    return {sif, sid, bex, sex, smem, busy, done, cnt};
  endfunction

  task automatic model_edge();
    if (m_act) begin
      if (flush_req || m_j == m_n) m_act = 1'b0;
      else m_j++;
    end else if (md_start_ex && !dmem_wait && !flush_req) begin
      m_act = 1'b1;
      m_j   = 0;
      m_n   = md_is_div_ex ? DIVN : MULN;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] dut_vec();
    return {stall_if, stall_id, bubble_ex, stall_ex, stall_mem, md_busy, md_done, md_cnt};
  endfunction

  // called at posedge+1 with inputs applied; checks mid-cycle then advances one edge
  task automatic cycle(input string tag);
    #3;
    chk(tag, 32'(dut_vec()), 32'(model_exp()));
    if (md_done) done_seen++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr_in();
    r1_r_id = 0; r2_r_id = 0; r1_id = 0; r2_id = 0; hilo_r_id = 0; md_start_id = 0;
    rw_ex = 0; din_sel_ex = DIN_ALU; rw_mem = 0; din_sel_mem = DIN_ALU;
    md_start_ex = 0; md_is_div_ex = 0; dmem_wait = 0; flush_req = 0;
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    clr_in();
    #2;
    chk("reset_state", 32'(dut_vec()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_reset", 32'(dut_vec()), 32'h0);

    // load-use: lw $5 in EX, ID reads rs=$5 -> 2 stall cycles
    r1_r_id = 1; r1_id = 5; rw_ex = 5; din_sel_ex = DIN_DM;
    cycle("lu_ex");
    rw_ex = 0; din_sel_ex = DIN_ALU; rw_mem = 5; din_sel_mem = DIN_DM;
    cycle("lu_mem");
    rw_mem = 0; din_sel_mem = DIN_ALU;
    cycle("lu_clear");
    // load targeting $0, and non-matching / rt matching cases
    rw_ex = 0; din_sel_ex = DIN_DM; r1_id = 0;
    cycle("lu_r0");
    rw_ex = 6; r1_id = 5; r2_r_id = 1; r2_id = 7;
    cycle("lu_nomatch");
    rw_ex = 0; rw_mem = 7; din_sel_mem = DIN_DM;
    cycle("lu_rt_mem");
    din_sel_mem = DIN_ALU;
    cycle("lu_alu_mem");
    clr_in();

    // mult with mflo waiting in ID
    done_seen = 0;
    md_start_ex = 1;
    cycle("mul_start");
    md_start_ex = 0; hilo_r_id = 1;
    for (int i = 0; i < MULN + 3; i++) cycle("mul_run");
    chk("mul_done_once", done_seen, 1);
    clr_in();

    // div flushed in its 10th busy cycle
    done_seen = 0;
    md_start_ex = 1; md_is_div_ex = 1;
    cycle("div_start");
    md_start_ex = 0; md_is_div_ex = 0; hilo_r_id = 1;
    for (int i = 0; i < 9; i++) cycle("div_busy");
    flush_req = 1;
    cycle("div_flush");
    flush_req = 0;
    for (int i = 0; i < 3; i++) cycle("div_after");
    chk("div_no_done", done_seen, 0);
    chk("div_idle_cnt", 32'(md_cnt), 0);
    clr_in();

    // start held through a 3-cycle dmem freeze
    done_seen = 0;
    md_start_ex = 1; dmem_wait = 1; r1_r_id = 1; r1_id = 3; rw_ex = 3; din_sel_ex = DIN_DM;
    for (int i = 0; i < 3; i++) cycle("freeze");
    dmem_wait = 0; r1_r_id = 0;
    cycle("freeze_release");
    md_start_ex = 0;
    for (int i = 0; i < MULN + 2; i++) cycle("freeze_run");
    chk("freeze_done_once", done_seen, 1);
    clr_in();

    // flush with a start in the same cycle: not accepted
    md_start_ex = 1; flush_req = 1;
    cycle("flush_start");
    md_start_ex = 0; flush_req = 0;
    cycle("flush_start_idle");

    // async reset in the middle of a busy mult
    md_start_ex = 1;
    cycle("rst_mul_start");
    md_start_ex = 0; hilo_r_id = 1;
    cycle("rst_mul_busy");
    #2;
    rst = 1'b1;
    m_act = 1'b0;
    #1;
    chk("rst_async", 32'(dut_vec()), 32'h0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    done_seen = 0;
    md_start_ex = 1;
    cycle("rst_fresh_start");
    md_start_ex = 0;
    for (int i = 0; i < MULN + 2; i++) cycle("rst_fresh_run");
    chk("rst_fresh_done", done_seen, 1);
    clr_in();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r1_r_id      = 1'($urandom_range(0, 1));
      r2_r_id      = 1'($urandom_range(0, 1));
      r1_id        = 5'($urandom_range(0, 3));
      r2_id        = 5'($urandom_range(0, 3));
      rw_ex        = 5'($urandom_range(0, 3));
      rw_mem       = 5'($urandom_range(0, 3));
      din_sel_ex   = 3'($urandom_range(0, 7));
      din_sel_mem  = 3'($urandom_range(0, 7));
      hilo_r_id    = ($urandom_range(0, 3) == 0);
      md_start_id  = ($urandom_range(0, 5) == 0);
      md_start_ex  = ($urandom_range(0, 3) == 0);
      md_is_div_ex = ($urandom_range(0, 3) == 0);
      dmem_wait    = ($urandom_range(0, 7) == 0);
      flush_req    = ($urandom_range(0, 15) == 0);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- ID-stage interlock controller.
- Handles the hazards the ID-stage register bypass network cannot resolve:
  - load-use, where dmout is not yet available in EX or MEM;
  - HI/LO reads and new mul/div issues while a multi-cycle mul/div is in flight;
  - data-memory wait freezes.
- Holds the sequencing FSM/counter of the mul/div unit.
- Drives the stall and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
MUL_CYCLES, 4, cycles in BUSY for a multiply (1..63)
DIV_CYCLES, 32, cycles in BUSY for a divide (1..63)

Ports:
clk  in  1  system clock; only clock
rst  in  1  reset, asynchronous, active-high
r1_r_id  in  1  ID instruction reads rs
r2_r_id  in  1  ID instruction reads rt
r1_id  in  5  rs index in ID
r2_id  in  5  rt index in ID
hilo_r_id  in  1  ID instruction reads HI/LO (mfhi/mflo)
md_start_id  in  1  ID instruction is mult/multu/div/divu
rw_ex  in  5  destination register in EX
din_sel_ex  in  3  writeback source select in EX
rw_mem  in  5  destination register in MEM
din_sel_mem  in  3  writeback source select in MEM
md_start_ex  in  1  mul/div instruction valid in EX
md_is_div_ex  in  1  1 = divide, 0 = multiply
dmem_wait  in  1  data memory not ready; freeze whole pipe
flush_req  in  1  exception/eret flush of IF..EX this cycle
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
bubble_ex  out  1  load NOP into ID/EX
stall_ex  out  1  hold ID/EX
stall_mem  out  1  hold EX/MEM and MEM/WB
md_busy  out  1  mul/div in flight (BUSY or DONE)
md_done  out  1  one-cycle HI/LO write enable
md_cnt  out  6  remaining BUSY cycles

Behaviour:
- Reset:
  - State is IDLE and md_cnt is 0.
  - All outputs are 0.
  - The reset is asynchronous, so it aborts a mul/div mid-operation with no md_done.
- Load-use hazard (lu):
  - Condition per source: (r1_r_id & r1_id==rw_ex & rw_ex!=0 & din_sel_ex==3'b010), or the same for r2.
  - The same condition is also checked against rw_mem/din_sel_mem.
  - A load directly ahead therefore costs 2 stall cycles. A load two instructions ahead costs 1.
- HI/LO hazard (hh): (hilo_r_id | md_start_id) & md_busy.
- md_start_ex & md_busy is a protocol error:
  - It cannot occur, because hh prevents it.
  - The start is ignored.
- Output priority, evaluated combinationally from the current inputs and registered state:
  1. dmem_wait=1: stall_if, stall_id, stall_ex and stall_mem are 1; bubble_ex is 0.
  2. Else flush_req=1: all stall and bubble outputs are 0. The killed instructions must not stall.
  3. Else lu|hh: stall_if, stall_id and bubble_ex are 1; stall_ex and stall_mem are 0.
  4. Else all are 0.
- Mul/div FSM (IDLE, BUSY, DONE), registered:
  - accept = md_start_ex & ~dmem_wait & ~flush_req & state==IDLE.
  - IDLE: on accept, go to BUSY and load md_cnt = (md_is_div_ex ? DIV_CYCLES : MUL_CYCLES) - 1.
  - BUSY:
    - If md_cnt==0, go to DONE; otherwise decrement md_cnt.
    - The counter runs regardless of dmem_wait, because the unit is independent of the pipe.
  - DONE: md_done=1 for exactly one cycle, then go to IDLE.
  - flush_req in BUSY or DONE: the next state is IDLE with md_cnt=0. If the FSM was in BUSY, no md_done is issued.
  - Latency: start sampled at edge t; md_done is high in the cycle after edge t+N (N = configured cycles).
  - A HI/LO reader stalled on hh leaves ID in the cycle after DONE. HI/LO is written at the end of DONE.
- Outputs: md_busy = (state != IDLE); md_done = (state == DONE); md_cnt is a registered output.
- Simultaneous events:
  - A start held across a dmem_wait freeze is accepted on the first cycle in which dmem_wait is 0. It is never double-launched.
  - flush_req with a start in the same cycle: the start is not accepted.

Decomposition:
- Shared package cpu_pkg:
  - din_sel encodings: DIN_PC8=3'b001, DIN_DM=3'b010, DIN_CP0=3'b011, DIN_HI=3'b100, DIN_LO=3'b101, DIN_ALU=3'b110. The bypass unit imports the same constants.
  - The md_state_t enum (IDLE, BUSY, DONE).
- One sub-module, md_seq_ctrl:
  - Contains the FSM and md_cnt.
  - Inputs: clk, rst, accept, is_div, flush_req.
  - Outputs: md_busy, md_done, md_cnt.
- Hazard detection and the priority mux stay in the top module.

Test Plan:
- lw to $5 in EX; ID reads r1=$5 (r1_r_id=1):
  - cycle 1: stall_if=stall_id=bubble_ex=1.
  - Next cycle, with the load in MEM: stall again.
  - Third cycle: all outputs 0.
- Load in EX with rw_ex=0, or ID reading a non-matching register: no stall.
- mult accepted at t with MUL_CYCLES=4:
  - md_busy=1 from t+1; md_cnt reads 3,2,1,0.
  - md_done=1 in exactly one cycle, at t+5.
  - mflo held in ID (hilo_r_id=1) is stalled t+1..t+5 and released at t+6.
- div (DIV_CYCLES=32) with flush_req at BUSY cycle 10: IDLE next cycle, md_cnt=0, md_done never asserted, stall outputs 0 during flush.
- md_start_ex high during a 3-cycle dmem_wait:
  - All four stall outputs are 1 and bubble_ex=0.
  - The FSM leaves IDLE on the first cycle after the wait drops, only once.
- rst asserted asynchronously mid-BUSY (between clock edges): all outputs are 0 immediately, and the next mult starts a fresh count.
